fpu_result_queue: RTL and testbench
===================================

FPU_RESULT_QUEUE -- requirements
Module: fpu_result_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result entries (power of two, >= 2).
REQ-002 SHALL have parameter TAG_W, default 6, width of the destination-register tag.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-high (1 = reset, sampled on clk rising edge).
REQ-005 SHALL have port in_y  input  32  single-precision result from the fadd stage.
REQ-006 SHALL have port in_tag  input  TAG_W  destination tag accompanying in_y.
REQ-007 SHALL have port in_valid  input  1  producer offers in_y/in_tag this cycle.
REQ-008 SHALL have port in_ready  output  1  queue can accept an entry this cycle.
REQ-009 SHALL have port out_y  output  32  head-entry result.
REQ-010 SHALL have port out_tag  output  TAG_W  head-entry tag.
REQ-011 SHALL have port out_valid  output  1  head entry present.
REQ-012 SHALL have port out_ready  input  1  writeback consumes head this cycle.
REQ-013 SHALL have port flush  input  1  discard all entries.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-015 SHALL push when in_valid && in_ready, and pop when out_valid && out_ready, both at the same clk edge.
REQ-016 SHALL drive in_ready = (count != DEPTH), independent of out_ready; a push offered while full SHALL be dropped even if a pop occurs that cycle.
REQ-017 SHALL drive out_valid = (count != 0); out_y/out_tag SHALL come from the storage entry at the read pointer (first-word fall-through, registered storage, no combinational path from in_* to out_*).
REQ-018 SHALL have latency 1: an entry pushed at edge N is visible at out_* during the cycle after edge N when the queue was empty.
REQ-019 SHALL maintain occupancy states EMPTY (count 0), PARTIAL (0 < count < DEPTH), FULL (count DEPTH); push-only +1, pop-only -1, push+pop 0.
REQ-020 SHALL, in EMPTY with in_valid and out_ready both high, accept the push and perform no pop (count 0 -> 1).
REQ-021 SHALL ignore out_ready while EMPTY; pointers and count unchanged.
REQ-022 SHALL advance write/read pointers modulo DEPTH; wrap from DEPTH-1 to 0 SHALL preserve FIFO order.
REQ-023 SHALL, when flush is high at an edge, set count, read and write pointers to 0; any push or pop in that cycle SHALL be discarded.
REQ-024 SHALL keep storage contents unchanged except on an accepted push; out_y/out_tag while out_valid=0 are don't-care.

Reset
REQ-025 SHALL, when rstn=1 at an edge, set count=0, pointers=0, out_valid=0, in_ready=1; reset SHALL take priority over flush, push and pop.
REQ-026 SHALL, on reset mid-operation, discard all held entries; first push after reset deasserted appears at out_* one cycle later.

Configuration
REQ-027 SHALL, with macro FPU_RQ_FLAGS_EN defined, add port out_flags  output  4  {sign, zero, inf, nan} of head entry, computed from in_y at push and stored per entry: zero = exp 0 (denormals are zero), inf = exp 255 and mantissa 0, nan = exp 255 and mantissa != 0, sign = bit 31.
REQ-028 SHALL, without FPU_RQ_FLAGS_EN, omit out_flags port and flag storage; all other behaviour identical.

Verification
REQ-029 SHALL cover: reset, then push in_y=0x3F800000 in_tag=5 with out_ready=0 -> next cycle out_valid=1, out_y=0x3F800000, out_tag=5, count=1.
REQ-030 SHALL cover: out_ready=0, push 0x1,0x2,0x3,0x4 -> count=4, in_ready=0; push 0x5 with out_ready=1 same cycle -> 0x5 dropped, count=3, out_y=0x2.
REQ-031 SHALL cover: count=2, simultaneous push and pop each cycle for 6 cycles (pointer wrap) -> count stays 2, outputs in exact push order.
REQ-032 SHALL cover: count=3, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1; pushed value absent.
REQ-033 SHALL cover: count=2, rstn=1 for one cycle with flush=1 and in_valid=1 -> count=0, out_valid=0; subsequent push 0x40000000 tag 9 emerges one cycle later.
REQ-034 SHALL cover (FPU_RQ_FLAGS_EN): push 0x7FC00000, 0xFF800000, 0x00000001 -> out_flags 4'b0001, 4'b1010, 4'b0100 in order.

Source files
------------

// File: rtl/fpu_result_queue.sv
// Result queue between the fadd stage and register writeback: a first-word
// fall-through FIFO with flush. Define FPU_RQ_FLAGS_EN to add per-entry class flags (out_flags).
module fpu_result_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [31:0]              in_y,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [31:0]              out_y,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     flush,
`ifdef FPU_RQ_FLAGS_EN
  output logic [3:0]               out_flags,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_t;

  occ_t            state_r;
  occ_t            state_nxt_s;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_nxt_s;
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   wr_ptr_nxt_s;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   rd_ptr_nxt_s;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            push_s;
  logic            pop_s;
  logic            wr_en_s;

  logic [31:0]       mem_y_r   [DEPTH];
  logic [TAG_W-1:0]  mem_tag_r [DEPTH];

`ifdef FPU_RQ_FLAGS_EN
  logic [3:0]        mem_flags_r [DEPTH];

  // {sign, zero, inf, nan}; denormals classify as zero
  function automatic logic [3:0] fp_class(input logic [31:0] y);
    logic [7:0]  e;
    logic [22:0] m;
    e = y[30:23];
    m = y[22:0];
    fp_class = {y[31],
                (e == 8'd0),
                (e == 8'hFF) && (m == 23'd0),
                (e == 8'hFF) && (m != 23'd0)};
  endfunction
`endif

  assign push_s  = in_valid && in_ready_r;
  assign pop_s   = out_valid_r && out_ready;
  assign wr_en_s = push_s && !flush && !rstn;

  // Next occupancy, pointers and state; flush clears everything and drops any push/pop
  always_comb begin
    count_nxt_s  = count_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    state_nxt_s  = state_r;
    if (flush) begin
      count_nxt_s  = {CW{1'b0}};
      wr_ptr_nxt_s = {PW{1'b0}};
      rd_ptr_nxt_s = {PW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
    if (count_nxt_s == CW'(0)) begin
      state_nxt_s = EMPTY;
    end else if (count_nxt_s == CW'(DEPTH)) begin
      state_nxt_s = FULL;
    end else begin
      state_nxt_s = PARTIAL;
    end
  end

  // Occupancy state, pointers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_r     <= EMPTY;
      count_r     <= {CW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      count_r     <= count_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      in_ready_r  <= (state_nxt_s != FULL);
      out_valid_r <= (state_nxt_s != EMPTY);
    end
  end

  // Entry storage is written only by an accepted push that is not cancelled
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_y_r[wr_ptr_r]     <= in_y;
      mem_tag_r[wr_ptr_r]   <= in_tag;
`ifdef FPU_RQ_FLAGS_EN
      mem_flags_r[wr_ptr_r] <= fp_class(in_y);
`endif
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign count     = count_r;
  assign out_y     = mem_y_r[rd_ptr_r];
  assign out_tag   = mem_tag_r[rd_ptr_r];
`ifdef FPU_RQ_FLAGS_EN
  assign out_flags = mem_flags_r[rd_ptr_r];
`endif

endmodule

// File: tb/tb_fpu_result_queue.sv
// Directed self-checking bench for fpu_result_queue (DEPTH=4, TAG_W=6).
module tb_fpu_result_queue;

  logic        clk;
  logic        rstn;
  logic [31:0] in_y;
  logic [5:0]  in_tag;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_y;
  logic [5:0]  out_tag;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;
`ifdef FPU_RQ_FLAGS_EN
  logic [3:0]  out_flags;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;

  fpu_result_queue #(.DEPTH(4), .TAG_W(6)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_y      (in_y),
    .in_tag    (in_tag),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_y     (out_y),
    .out_tag   (out_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
`ifdef FPU_RQ_FLAGS_EN
    .out_flags (out_flags),
`endif
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] y, input logic [5:0] t);
    in_valid = 1'b1;
    in_y     = y;
    in_tag   = t;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b1; in_y = 32'd0; in_tag = 6'd0; in_valid = 1'b0;
    out_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    rstn = 1'b0;
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_ovalid", 32'(out_valid), 32'd0);
    check_val("rst_iready", 32'(in_ready), 32'd1);

    // first push, latency 1
    push(32'h3F800000, 6'd5);
    check_val("p1_ovalid", 32'(out_valid), 32'd1);
    check_val("p1_y", out_y, 32'h3F800000);
    check_val("p1_tag", 32'(out_tag), 32'd5);
    check_val("p1_count", 32'(count), 32'd1);
    out_ready = 1'b1; tick();
    check_val("p1_drain", 32'(count), 32'd0);
    // out_ready while empty is ignored
    tick();
    check_val("empty_pop", 32'(count), 32'd0);
    out_ready = 1'b0;

    // fill, then push while full with a pop: push dropped
    for (int i = 1; i <= 4; i++) push(32'(i), 6'(i));
    check_val("full_count", 32'(count), 32'd4);
    check_val("full_iready", 32'(in_ready), 32'd0);
    check_val("full_head", out_y, 32'd1);
    in_valid = 1'b1; in_y = 32'd5; in_tag = 6'd5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check_val("drop_count", 32'(count), 32'd3);
    check_val("drop_head", out_y, 32'd2);
    check_val("drop_iready", 32'(in_ready), 32'd1);
    for (int i = 2; i <= 4; i++) begin
      check_val("drain_order", out_y, 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check_val("drain_count", 32'(count), 32'd0);
    check_val("drain_ovalid", 32'(out_valid), 32'd0);

    // steady push+pop across pointer wrap
    push(32'h100, 6'd0);
    push(32'h101, 6'd1);
    for (int i = 0; i < 6; i++) begin
      check_val("wrap_head", out_y, 32'h100 + 32'(i));
      in_valid = 1'b1; in_y = 32'h102 + 32'(i); in_tag = 6'(i + 2); out_ready = 1'b1;
      tick();
      check_val("wrap_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    check_val("wrap_tail0", out_y, 32'h106);
    check_val("wrap_tag0", 32'(out_tag), 32'd6);
    tick();
    check_val("wrap_tail1", out_y, 32'h107);
    tick();
    out_ready = 1'b0;
    check_val("wrap_empty", 32'(count), 32'd0);

    // flush with a concurrent push
    for (int i = 0; i < 3; i++) push(32'h200 + 32'(i), 6'(i));
    check_val("pre_flush", 32'(count), 32'd3);
    flush = 1'b1; in_valid = 1'b1; in_y = 32'hDEADBEEF; in_tag = 6'd63;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush_count", 32'(count), 32'd0);
    check_val("flush_ovalid", 32'(out_valid), 32'd0);
    check_val("flush_iready", 32'(in_ready), 32'd1);
    push(32'h11, 6'd1);
    check_val("post_flush_y", out_y, 32'h11);
    check_val("post_flush_cnt", 32'(count), 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // reset beats flush and push mid-operation
    push(32'h300, 6'd3);
    push(32'h301, 6'd4);
    rstn = 1'b1; flush = 1'b1; in_valid = 1'b1; in_y = 32'hBAD0BAD0;
    tick();
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check_val("mrst_count", 32'(count), 32'd0);
    check_val("mrst_ovalid", 32'(out_valid), 32'd0);
    push(32'h40000000, 6'd9);
    check_val("mrst_ovalid1", 32'(out_valid), 32'd1);
    check_val("mrst_y", out_y, 32'h40000000);
    check_val("mrst_tag", 32'(out_tag), 32'd9);
    out_ready = 1'b1; tick();

    // empty with push and out_ready both high: push only
    check_val("pp_empty_pre", 32'(count), 32'd0);
    in_valid = 1'b1; in_y = 32'h77; in_tag = 6'd7;
    tick();
    in_valid = 1'b0;
    check_val("pp_empty_cnt", 32'(count), 32'd1);
    check_val("pp_empty_y", out_y, 32'h77);
    tick();
    out_ready = 1'b0;
    check_val("pp_empty_drain", 32'(count), 32'd0);

`ifdef FPU_RQ_FLAGS_EN
    push(32'h7FC00000, 6'd1);
    push(32'hFF800000, 6'd2);
    push(32'h00000001, 6'd3);
    check_val("flags_nan", 32'(out_flags), 32'h1);
    out_ready = 1'b1; tick();
    check_val("flags_ninf", 32'(out_flags), 32'hA);
    tick();
    check_val("flags_zero", 32'(out_flags), 32'h4);
    tick();
    out_ready = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
